// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared pipeline types and constants for the execute stage
package common;

  typedef logic [4:0] regaddr_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_COPY2
  } alu_mode_t;

  typedef enum logic [1:0] {
    MA_MODE_NONE,
    MA_MODE_LOAD,
    MA_MODE_STORE
  } ma_mode_t;

  typedef enum logic [1:0] {
    MA_SIZE_B,
    MA_SIZE_H,
    MA_SIZE_W
  } ma_size_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_MEM,
    WB_SRC_PC4
  } wb_src_t;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] alu_result;
    ma_mode_t    ma_mode;
    ma_size_t    ma_size;
    logic [31:0] ma_data;
    wb_src_t     wb_src;
  } ex_entry_t;

  function automatic ex_entry_t entry_reset();
    ex_entry_t e;
    e.ir         = NOP;
    e.alu_result = 32'h0;
    e.ma_mode    = MA_MODE_NONE;
    e.ma_size    = MA_SIZE_B;
    e.ma_data    = 32'h0;
    e.wb_src     = WB_SRC_NONE;
    return e;
  endfunction

endpackage

// File: rtl/stage_execute_alu.sv
// rtl/stage_execute_alu.sv - combinational ALU for the execute stage
module alu
  import common::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  alu_mode_t   mode,
  output logic [31:0] result
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  always_comb begin
    result = 32'h0;
    case (mode)
      ALU_ADD:   result = op1 + op2;
      ALU_SUB:   result = op1 - op2;
      ALU_SLL:   result = op1 << shamt;
      ALU_SRL:   result = op1 >> shamt;
      ALU_SRA:   result = $unsigned($signed(op1) >>> shamt);
      ALU_SLT:   result = {31'h0, $signed(op1) < $signed(op2)};
      ALU_SLTU:  result = {31'h0, op1 < op2};
      ALU_XOR:   result = op1 ^ op2;
      ALU_OR:    result = op1 | op2;
      ALU_AND:   result = op1 & op2;
      ALU_COPY2: result = op2;
      default:   result = 32'h0;
    endcase
  end

endmodule

// File: rtl/stage_execute.sv
// rtl/stage_execute.sv - execute stage with main output register and one-entry skid buffer
module stage_execute
  import common::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        id_valid,
  input  logic [31:0] id_ir,
  input  logic [31:0] id_alu_op1,
  input  logic [31:0] id_alu_op2,
  input  alu_mode_t   id_alu_mode,
  input  ma_mode_t    id_ma_mode,
  input  ma_size_t    id_ma_size,
  input  logic [31:0] id_ma_data,
  input  wb_src_t     id_wb_src,
  output logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_ir,
  output logic [31:0] ex_alu_result,
  output ma_mode_t    ex_ma_mode,
  output ma_size_t    ex_ma_size,
  output logic [31:0] ex_ma_data,
  output wb_src_t     ex_wb_src,
  input  logic        ma_ready,
  output regaddr_t    hz_ex_wb_addr,
  output logic [31:0] hz_ex_wb_data,
  output logic        hz_ex_wb_valid
);

  logic [31:0] alu_result;
  ex_entry_t   incoming;
  ex_entry_t   main_q;
  ex_entry_t   skid_q;
  logic        valid_q;
  logic        skid_full;
  logic        id_xfer;

  alu u_alu (
    .op1    (id_alu_op1),
    .op2    (id_alu_op2),
    .mode   (id_alu_mode),
    .result (alu_result)
  );

  always_comb begin
    incoming.ir         = id_ir;
    incoming.alu_result = alu_result;
    incoming.ma_mode    = id_ma_mode;
    incoming.ma_size    = id_ma_size;
    incoming.ma_data    = id_ma_data;
    incoming.wb_src     = id_wb_src;
  end

  // ex_ready comes straight from the skid flop, so ma_ready never reaches it
  assign ex_ready = ~skid_full;
  assign id_xfer  = id_valid & ex_ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      skid_full <= 1'b0;
      main_q    <= entry_reset();
      skid_q    <= entry_reset();
    end else if (skid_full) begin
      if (ma_ready) begin
        main_q    <= skid_q;
        skid_full <= 1'b0;
      end
    end else if (id_xfer) begin
      if (!valid_q || ma_ready) begin
        main_q  <= incoming;
        valid_q <= 1'b1;
      end else begin
        skid_q    <= incoming;
        skid_full <= 1'b1;
      end
    end else if (ma_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_ir         = main_q.ir;
  assign ex_alu_result = main_q.alu_result;
  assign ex_ma_mode    = main_q.ma_mode;
  assign ex_ma_size    = main_q.ma_size;
  assign ex_ma_data    = main_q.ma_data;
  assign ex_wb_src     = main_q.wb_src;

  // Forwarding looks only at the main register; a skidded instruction is younger
  always_comb begin
    hz_ex_wb_addr = 5'd0;
    if (valid_q && main_q.wb_src != WB_SRC_NONE) begin
      hz_ex_wb_addr = main_q.ir[11:7];
    end
  end

  assign hz_ex_wb_data  = (hz_ex_wb_addr != 5'd0) ? main_q.alu_result : 32'h0;
  assign hz_ex_wb_valid = ~(valid_q && main_q.wb_src == WB_SRC_MEM);

endmodule

// File: doc/stage_execute.md
STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i in 1 (clock, all state on rising edge); reset_i in 1 (async active-high reset).
REQ-002 The block SHALL have these inputs from ID: id_valid in 1 (ID outputs valid); id_ir in 32 (instruction); id_alu_op1 in 32; id_alu_op2 in 32; id_alu_mode in alu_mode_t; id_ma_mode in ma_mode_t; id_ma_size in ma_size_t; id_ma_data in 32 (store data); id_wb_src in wb_src_t.
REQ-003 The block SHALL have ex_ready out 1 (EX accepts an ID transfer this cycle).
REQ-004 The block SHALL have these outputs to MA: ex_valid out 1; ex_ir out 32; ex_alu_result out 32 (memory address or write-back value); ex_ma_mode out ma_mode_t; ex_ma_size out ma_size_t; ex_ma_data out 32; ex_wb_src out wb_src_t.
REQ-005 The block SHALL have ma_ready in 1 (MA accepts an EX transfer this cycle).
REQ-006 The block SHALL drive these hazard outputs to ID: hz_ex_wb_addr out regaddr_t; hz_ex_wb_data out 32; hz_ex_wb_valid out 1 (forwarded data usable).

Function
REQ-007 An ID->EX transfer SHALL occur on a rising edge where id_valid && ex_ready; an EX->MA transfer SHALL occur where ex_valid && ma_ready.
REQ-008 The ALU result SHALL be computed combinationally from the instruction being captured and registered with it: latency 1 cycle, throughput 1 instruction/cycle while ma_ready=1.
REQ-009 ALU modes: ADD, SUB (mod 2^32); SLL, SRL, SRA (shift amount = op2[4:0]); SLT signed and SLTU unsigned (result 0 or 1); XOR, OR, AND; COPY2 (result = op2, for LUI).
REQ-010 Staging SHALL be a main output register plus a one-entry skid register.
REQ-011 The main register SHALL load from ID when a transfer occurs and (!ex_valid || ma_ready) and the skid is empty.
REQ-012 If an ID transfer occurs while ex_valid && !ma_ready, the incoming instruction SHALL go to the skid register and skid_full SHALL set.
REQ-013 ex_ready SHALL be registered and equal !skid_full; no combinational path from ma_ready to ex_ready is allowed.
REQ-014 While skid_full && ma_ready, the main register SHALL load from the skid and skid_full SHALL clear. ex_ready returns to 1 the next cycle.
REQ-015 With the main register empty or draining and no ID transfer, ex_valid SHALL drop to 0 (bubble). Register contents are don't-care when ex_valid=0.
REQ-016 Order SHALL be preserved; no instruction is dropped or duplicated under any ma_ready/id_valid pattern.
REQ-017 Hazard outputs SHALL reflect the main register: hz_ex_wb_addr = ex_ir[11:7] when ex_valid and ex_wb_src != WB_SRC_NONE, else 0.
REQ-018 hz_ex_wb_data SHALL equal ex_alu_result (PC+4 when wb_src = WB_SRC_PC4). It SHALL be 0 when hz_ex_wb_addr = 0.
REQ-019 hz_ex_wb_valid SHALL be 0 only when ex_valid and ex_wb_src = WB_SRC_MEM (load pending); otherwise it is 1.
REQ-020 The skid register SHALL NOT drive the hazard outputs.

Reset
REQ-021 Reset SHALL act asynchronously and apply to: ex_valid=0, skid_full=0, ex_ready=1, ex_ir=32'h00000013 (NOP), ex_alu_result=0, ex_ma_data=0, ex_ma_mode=MA_MODE_NONE, ex_wb_src=WB_SRC_NONE, hz_ex_wb_addr=0, hz_ex_wb_data=0, hz_ex_wb_valid=1.
REQ-022 Reset asserted mid-stream SHALL discard both the main and skid entries. The first transfer after deassertion is accepted on the first rising edge.

Structure
REQ-023 alu_mode_t, ma_mode_t, ma_size_t, wb_src_t, regaddr_t and the NOP constant SHALL come from package common.
REQ-024 The ALU SHALL be a separate purely combinational sub-module named alu (ports op1, op2, mode, result).

Verification
REQ-025 ADD: op1=32'h7FFFFFFF, op2=1, ma_ready=1 -> next cycle ex_alu_result=32'h80000000, ex_valid=1.
REQ-026 SRA: op1=32'h80000000, op2=32'h00000024 (amount 4) -> ex_alu_result=32'hF8000000. SLTU with op1=1, op2=32'hFFFFFFFF -> 1. SLT with the same operands -> 0.
REQ-027 Backpressure: stream I1..I4, ma_ready=0 for 3 cycles -> ex_ready falls 1 cycle after skid fill. With ma_ready=1, MA receives I1,I2,I3,I4 in order with no gaps.
REQ-028 Hazard: load (wb_src=WB_SRC_MEM, rd=x5) in EX -> hz_ex_wb_addr=5, hz_ex_wb_valid=0. ADDI to x0 -> addr 0, data 0, valid 1.
REQ-029 Reset with skid_full=1 -> outputs asynchronously at reset values. After release, the next ID instruction appears alone on ex_valid.
